// File: rtl/b8to3_encoder_seq_pkg.sv
// ============================================================================
// b8to3_encoder_seq_pkg : shared widths and state encoding for the encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package b8to3_encoder_seq_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/b8to3_prio_encoder.sv
// ============================================================================
// b8to3_prio_encoder : combinational lowest-set-bit index encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module b8to3_prio_encoder
  import b8to3_encoder_seq_pkg::*;
(
  input  logic [IN_W-1:0]  x,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan downwards so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (x[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/b8to3_encoder_seq.sv
// ============================================================================
// b8to3_encoder_seq : emits the binary index of every set request bit,
//                     lowest first, one per output handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module b8to3_encoder_seq
  import b8to3_encoder_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  x7_x0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] z2_z0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic [CNT_W-1:0] cnt3_cnt0,
  output logic             zero
);

  state_t           state_q;
  logic [IN_W-1:0]  pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q;

  logic [IDX_W-1:0] idx_w;
  logic             any_w;
  logic [IN_W-1:0]  pend_d;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < IN_W; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  b8to3_prio_encoder u_prio (
    .x   (pend_q),
    .idx (idx_w),
    .any (any_w)
  );

  // Values taken on an output handshake: retire the current index.
  assign pend_d = pend_q & ~(IN_W'(1) << idx_w);
  assign cnt_d  = cnt_q - CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pend_q <= x7_x0;
            cnt_q  <= popcount(x7_x0);
            if (x7_x0 != '0) begin
              state_q <= EMIT;
            end else begin
              zero_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready && any_w) begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            if (cnt_q == CNT_W'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign z2_z0     = idx_w;
  assign last      = out_valid && (cnt_q == CNT_W'(1));
  assign cnt3_cnt0 = cnt_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_b8to3_encoder_seq.sv
// ============================================================================
// tb_b8to3_encoder_seq : directed and randomized checks against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_b8to3_encoder_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] x7_x0;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] z2_z0;
  logic       out_valid;
  logic       out_ready;
  logic       last;
  logic [3:0] cnt3_cnt0;
  logic       zero;

  int checks = 0;
  int errors = 0;

  b8to3_encoder_seq dut (
    .clock     (clock),
    .reset     (reset),
    .x7_x0     (x7_x0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z2_z0     (z2_z0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last),
    .cnt3_cnt0 (cnt3_cnt0),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the pending indices of the current vector, in emission order.
  int q[$];
  bit zero_m = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      zero_m = 1'b0;
    end else begin
      zero_m = 1'b0;
      if (q.size() == 0) begin
        if (in_valid === 1'b1) begin
          for (int i = 0; i < 8; i++) if (x7_x0[i]) q.push_back(i);
          if (x7_x0 == 8'h00) zero_m = 1'b1;
        end
      end else if (out_ready === 1'b1) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      chk("m_in_ready",  int'(in_ready),  int'(q.size() == 0));
      chk("m_out_valid", int'(out_valid), int'(q.size() != 0));
      chk("m_z",         int'(z2_z0),     (q.size() != 0) ? q[0] : 0);
      chk("m_last",      int'(last),      int'(q.size() == 1));
      chk("m_cnt",       int'(cnt3_cnt0), q.size());
      chk("m_zero",      int'(zero),      int'(zero_m));
    end
  end

  task automatic lit(input string tag, input int ov, input int z, input int c, input int l);
    chk({tag, "_out_valid"}, int'(out_valid), ov);
    chk({tag, "_z"},         int'(z2_z0),     z);
    chk({tag, "_cnt"},       int'(cnt3_cnt0), c);
    chk({tag, "_last"},      int'(last),      l);
  endtask

  initial begin
    reset = 1'b1; x7_x0 = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    lit("rst", 0, 0, 0, 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_zero", int'(zero), 0);
    reset = 1'b0;

    // single bit
    @(negedge clock); x7_x0 = 8'b0000_0001; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    lit("one", 1, 0, 1, 1);
    @(negedge clock);
    chk("one_in_ready_after", int'(in_ready), 1);

    // three bits, free-flowing
    x7_x0 = 8'b1010_0100; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    lit("a4_0", 1, 2, 3, 0);
    @(negedge clock); lit("a4_1", 1, 5, 2, 0);
    @(negedge clock); lit("a4_2", 1, 7, 1, 1);
    @(negedge clock);

    // back-pressure with ignored in_valid pulses
    x7_x0 = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      lit("hold", 1, 2, 3, 0);
      chk("hold_in_ready", int'(in_ready), 0);
      x7_x0 = 8'hFF; in_valid = (i != 1);
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    lit("hold_rel", 1, 2, 3, 0);
    @(negedge clock); lit("hold_5", 1, 5, 2, 0);
    @(negedge clock); lit("hold_7", 1, 7, 1, 1);
    @(negedge clock);

    // zero vector
    x7_x0 = 8'h00; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    chk("zero_pulse", int'(zero), 1);
    chk("zero_ov", int'(out_valid), 0);
    chk("zero_ir", int'(in_ready), 1);
    @(negedge clock);
    chk("zero_gone", int'(zero), 0);

    // all ones
    x7_x0 = 8'hFF; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lit("ff", 1, i, 8 - i, int'(i == 7));
      @(negedge clock);
    end
    chk("ff_done_ir", int'(in_ready), 1);

    // reset mid-emission
    x7_x0 = 8'hF0; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    lit("f0_4", 1, 4, 4, 0);
    #1 reset = 1'b1;
    #1;
    lit("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_ir", int'(in_ready), 1);
    @(negedge clock); reset = 1'b0;
    x7_x0 = 8'h81; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    lit("post_0", 1, 0, 2, 0);
    @(negedge clock); lit("post_7", 1, 7, 1, 1);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(0, 3) != 0);
      x7_x0     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
